// File: rtl/prefix_subtractor_pipe.sv
// Two-stage pipelined subtractor recovering b = sum - a, with range error flag.
// Optional saturating error counter on port err_cnt when SUB_ERRCNT_EN is defined.
module prefix_subtractor_pipe #(
    parameter int WIDTH = 12,
    parameter int SPLIT = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   in_sum,
    input  logic [WIDTH-1:0] in_a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_b,
    output logic             out_err,
    output logic             busy
`ifdef SUB_ERRCNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    localparam int HI = WIDTH - SPLIT;

    logic             s1_valid;
    logic [SPLIT-1:0] s1_lo;
    logic             s1_borrow;
    logic [HI:0]      s1_sum_hi;
    logic [HI-1:0]    s1_a_hi;

    logic             s2_free;
    logic             advance;
    logic             take;
    logic             emit;
    logic [SPLIT:0]   lo_diff;
    logic [HI+1:0]    hi_diff;

    assign s2_free  = ~out_valid | out_ready;
    assign advance  = s1_valid & s2_free;
    assign in_ready = ~s1_valid | s2_free;
    assign take     = in_valid & in_ready;
    assign emit     = out_valid & out_ready;
    assign busy     = s1_valid | out_valid;

    // Low-half subtraction; the extra MSB carries the borrow into stage 2.
    assign lo_diff = {1'b0, in_sum[SPLIT-1:0]} - {1'b0, in_a[SPLIT-1:0]};

    // Upper subtraction: bit HI+1 means sum < a, bit HI means diff >= 2^WIDTH.
    assign hi_diff = {1'b0, s1_sum_hi}
                   - {2'b00, s1_a_hi}
                   - {{(HI + 1){1'b0}}, s1_borrow};

    // Stage 1: capture low difference, borrow and the raw upper operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_lo     <= '0;
            s1_borrow <= 1'b0;
            s1_sum_hi <= '0;
            s1_a_hi   <= '0;
        end else begin
            if (take) begin
                s1_valid  <= 1'b1;
                s1_lo     <= lo_diff[SPLIT-1:0];
                s1_borrow <= lo_diff[SPLIT];
                s1_sum_hi <= in_sum[WIDTH:SPLIT];
                s1_a_hi   <= in_a[WIDTH-1:SPLIT];
            end else if (advance) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2: finish the subtraction and hold the result until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_b     <= '0;
            out_err   <= 1'b0;
        end else begin
            if (advance) begin
                out_valid <= 1'b1;
                out_b     <= {hi_diff[HI-1:0], s1_lo};
                out_err   <= hi_diff[HI+1] | hi_diff[HI];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef SUB_ERRCNT_EN
    // Count erroring results as they leave; saturate at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else if (emit && out_err && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    logic unused_emit;
    assign unused_emit = emit;
`endif

endmodule

// File: tb/tb_prefix_subtractor_pipe.sv
// Scoreboard bench for prefix_subtractor_pipe: directed, backpressure,
// reset mid-flight, random traffic, and the optional error counter.
module tb_prefix_subtractor_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [12:0] in_sum = '0;
    logic [11:0] in_a = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_b;
    logic        out_err;
    logic        busy;
`ifdef SUB_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [12:0] q[$];
    int          model_cnt = 0;
    logic        last_ov = 1'b0;
    logic        last_ir = 1'b0;
    logic        hold = 1'b0;
    logic [12:0] hold_val = '0;

    always #5 clk = ~clk;

    prefix_subtractor_pipe #(.WIDTH(12), .SPLIT(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_a      (in_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_b     (out_b),
        .out_err   (out_err),
        .busy      (busy)
`ifdef SUB_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] model(input logic [12:0] s,
                                          input logic [11:0] a);
        int d;
        logic [11:0] b;
        logic e;
        d = int'(s) - int'(a);
        b = 12'(d);
        e = (d < 0) || (d >= 4096);
        return {e, b};
    endfunction

    // One clock cycle: drive at the falling edge, sample 1ns later.
    task automatic step(input logic iv, input logic [12:0] s,
                        input logic [11:0] a, input logic ordy,
                        output logic acc);
        logic [12:0] e;
        in_valid = iv;
        in_sum = s;
        in_a = a;
        out_ready = ordy;
        #1;
        if (hold) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", {out_err, out_b}, hold_val);
        end
        hold = out_valid && !out_ready;
        hold_val = {out_err, out_b};
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                e = q.pop_front();
                check("out_b", out_b, e[11:0]);
                check("out_err", out_err, e[12]);
                if (e[12] && model_cnt < 255) model_cnt++;
            end
        end
        last_ov = out_valid;
        last_ir = in_ready;
        acc = iv && in_ready;
        if (acc) q.push_back(model(s, a));
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        step(1'b0, 13'h0, 12'h0, ordy, acc);
    endtask

    task automatic send(input logic [12:0] s, input logic [11:0] a);
        logic acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            step(1'b1, s, a, 1'b1, acc);
            n++;
        end
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 50) begin
            idle(1'b1);
            n++;
        end
        check("drain_empty", q.size(), 0);
    endtask

`ifdef SUB_ERRCNT_EN
    task automatic check_cnt(input string tag);
        #1;
        check(tag, err_cnt, model_cnt);
        @(negedge clk);
    endtask
`endif

    logic [12:0] dsum[6] = '{13'h1FFE, 13'h0005, 13'h1000,
                             13'h0040, 13'h0800, 13'h0FFF};
    logic [11:0] da[6]   = '{12'hFFF, 12'h007, 12'h000,
                             12'h001, 12'h7FF, 12'hFFF};

    initial begin
        logic acc;
        logic [12:0] bs[4];
        logic [11:0] ba[4];
        int idx;
        int accepted;
        logic pend;
        logic [12:0] ps;
        logic [11:0] pa;

        @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_b", out_b, 0);
        check("rst_out_err", out_err, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency and single-cycle valid pulse.
        step(1'b1, 13'h1FFE, 12'hFFF, 1'b1, acc);
        check("lat_accept", acc, 1);
        idle(1'b1);
        check("lat_cycle1", last_ov, 0);
        idle(1'b1);
        check("lat_cycle2", last_ov, 1);
        idle(1'b1);
        check("lat_pulse", last_ov, 0);
        check("lat_q_empty", q.size(), 0);

        // Directed error and SPLIT-boundary borrow cases, back to back.
        for (int i = 0; i < 6; i++) send(dsum[i], da[i]);
        drain();

        // Backpressure: four items b=1..4 with the output stalled.
        for (int i = 0; i < 4; i++) begin
            ba[i] = 12'(12'h100 * (i + 1));
            bs[i] = {1'b0, ba[i]} + 13'(i + 1);
        end
        idx = 0;
        accepted = 0;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, bs[idx], ba[idx], 1'b0, acc);
            if (acc) begin
                idx++;
                accepted++;
            end
        end
        check("bp_accepted", accepted, 2);
        check("bp_in_ready", last_ir, 0);
        check("bp_busy", busy, 1);
        while (idx < 4) begin
            step(1'b1, bs[idx], ba[idx], 1'b1, acc);
            if (acc) idx++;
        end
        drain();

        // Reset with both stages full.
        step(1'b1, 13'h0123, 12'h023, 1'b0, acc);
        step(1'b1, 13'h0456, 12'h056, 1'b0, acc);
        step(1'b1, 13'h0789, 12'h089, 1'b0, acc);
        check("mf_full", last_ir, 0);
        rst_n = 1'b0;
        #1;
        check("mf_out_valid", out_valid, 0);
        check("mf_busy", busy, 0);
        q.delete();
        hold = 1'b0;
        model_cnt = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);
        check("mf_in_ready", last_ir, 1);
        for (int c = 0; c < 4; c++) idle(1'b1);
        check("mf_no_output", last_ov, 0);

        // Random traffic with random stalls; hold offers until taken.
        pend = 1'b0;
        ps = '0;
        pa = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pend && $urandom_range(0, 9) < 7) begin
                pend = 1'b1;
                ps = 13'($urandom);
                pa = 12'($urandom);
                if ($urandom_range(0, 3) == 0) ps = {1'b0, pa} + 13'($urandom_range(0, 70));
            end
            step(pend, ps, pa, 1'($urandom_range(0, 3) != 0), acc);
            if (acc) pend = 1'b0;
        end
        drain();

`ifdef SUB_ERRCNT_EN
        check_cnt("cnt_random");
        for (int i = 0; i < 300; i++) send(13'h0000, 12'h001);
        drain();
        check_cnt("cnt_saturate");
        send(13'h0010, 12'h001);
        drain();
        check_cnt("cnt_hold");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
